fan_line_packer: RTL and testbench

//  Injection end of the FAN reduction network. Accepts a serial valid/ready stream of

---
 rtl/fan_pkg.sv | 41 ++++
 rtl/fan_line_packer_if.sv | 34 +++
 rtl/fan_ctrl_gen.sv | 44 ++++
 rtl/fan_line_packer.sv | 173 +++++++++++++++++
 tb/tb_fan_line_packer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fan_pkg.sv
// fan_pkg -- shared definitions for the FAN reduction network.
//
// Holds the lane geometry (data/row/ctrl widths), the derived lane width,
// the ctrl bit positions used by every adder stage, the lane field offsets
// and a helper that packs one lane as {ctrl, row, data}.
// Used by fan_line_packer, fan_ctrl_gen and the fan_adder stages.
package fan_pkg;

  localparam int N_STACK  = 4;   // data words stacked per lane
  localparam int DW_DATA  = 32;  // bits per data word
  localparam int DW_ROW   = 4;   // row-index width
  localparam int DW_CTRL  = 4;   // ctrl-field width (>= 3)
  localparam int NUM_LANE = 8;   // lanes per line (power of 2, >= 2)

  localparam int DW_PAYLOAD = N_STACK * DW_DATA;
  localparam int DW_LINE    = DW_PAYLOAD + DW_ROW + DW_CTRL;

  // Ctrl bit positions inside a lane's ctrl field
  localparam int CTRL_VALID  = DW_CTRL - 1;  // lane carries a product
  localparam int CTRL_CONT_R = 0;            // same row continues in lane i+1
  localparam int CTRL_CONT_L = 1;            // same row continues from lane i-1

  // Field offsets inside one lane
  localparam int LANE_DATA_LSB = 0;
  localparam int LANE_ROW_LSB  = DW_PAYLOAD;
  localparam int LANE_CTRL_LSB = DW_PAYLOAD + DW_ROW;

  // Fill counter must be able to hold NUM_LANE itself
  localparam int DW_CNT = $clog2(NUM_LANE) + 1;

  typedef logic [DW_PAYLOAD-1:0]       data_t;
  typedef logic [DW_ROW-1:0]           row_t;
  typedef logic [DW_CTRL-1:0]          ctrl_t;
  typedef logic [DW_LINE-1:0]          lane_t;
  typedef logic [NUM_LANE*DW_LINE-1:0] line_t;

  function automatic lane_t pack_lane(input ctrl_t ctrl, input row_t row, input data_t data);
    return {ctrl, row, data};
  endfunction

endpackage

// File: rtl/fan_line_packer_if.sv
// fan_line_packer_if -- handshake bundle around the FAN line packer.
//
// Input stream  : s_valid / s_ready / s_data / s_row / s_last
// Output stream : m_valid / m_ready / m_line
// Both streams use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1; the sender holds valid and payload
// stable until that edge, and ready may depend combinationally on the
// receiver's own state only.
//
// master : the environment (drives s_*, m_ready)
// slave  : the packer      (drives s_ready, m_valid, m_line)
interface fan_line_packer_if;
  import fan_pkg::*;

  logic  s_valid;
  logic  s_ready;
  data_t s_data;
  row_t  s_row;
  logic  s_last;
  logic  m_valid;
  logic  m_ready;
  line_t m_line;

  modport master (
    output s_valid, s_data, s_row, s_last, m_ready,
    input  s_ready, m_valid, m_line
  );

  modport slave (
    input  s_valid, s_data, s_row, s_last, m_ready,
    output s_ready, m_valid, m_line
  );

endinterface

// File: rtl/fan_ctrl_gen.sv
// fan_ctrl_gen -- combinational neighbour compare for one FAN line.
//
// Ports:
//   valid  in  NUM_LANE           per-lane valid mask
//   rows   in  NUM_LANE*DW_ROW    per-lane row index, lane i at [i*DW_ROW +: DW_ROW]
//   ctrl   out NUM_LANE*DW_CTRL   per-lane ctrl field, lane i at [i*DW_CTRL +: DW_CTRL]
//
// ctrl[CTRL_VALID] mirrors the lane valid; CONT_R/CONT_L flag that the
// right/left neighbour holds the same row. Edge lanes never flag outward.
module fan_ctrl_gen
  import fan_pkg::*;
(
  input  logic [NUM_LANE-1:0]         valid,
  input  logic [NUM_LANE*DW_ROW-1:0]  rows,
  output logic [NUM_LANE*DW_CTRL-1:0] ctrl
);

  for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
    logic cont_r;
    logic cont_l;

    if (i < NUM_LANE - 1) begin : g_right
      assign cont_r = valid[i] && valid[i+1] &&
                      (rows[i*DW_ROW +: DW_ROW] == rows[(i+1)*DW_ROW +: DW_ROW]);
    end else begin : g_right_edge
      assign cont_r = 1'b0;
    end

    if (i > 0) begin : g_left
      assign cont_l = valid[i] && valid[i-1] &&
                      (rows[i*DW_ROW +: DW_ROW] == rows[(i-1)*DW_ROW +: DW_ROW]);
    end else begin : g_left_edge
      assign cont_l = 1'b0;
    end

    always_comb begin
      ctrl[i*DW_CTRL +: DW_CTRL]              = '0;
      ctrl[i*DW_CTRL + CTRL_VALID]            = valid[i];
      ctrl[i*DW_CTRL + CTRL_CONT_R]           = cont_r;
      ctrl[i*DW_CTRL + CTRL_CONT_L]           = cont_l;
    end
  end

endmodule

// File: rtl/fan_line_packer.sv
// fan_line_packer -- injection end of the FAN reduction network.
//
// Packs a serial stream of (data, row) products into NUM_LANE-lane lines,
// tags every lane with ctrl flags from fan_ctrl_gen, and hands lines to the
// first adder stage through a single output register.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   bus        slave modport of fan_line_packer_if (s_* in, m_* out)
//   stat_lines out  32-bit count of lines handed off   (FAN_PACK_STATS_EN)
//   stat_pad   out  32-bit count of padded lanes sent  (FAN_PACK_STATS_EN)
//
// Configuration macro: FAN_PACK_STATS_EN adds the two statistics counters.
//
// A line closes when the NUM_LANE-th element or an s_last element is
// accepted. A closing line goes straight into the output register when that
// register is free this cycle; otherwise it parks in the fill buffer
// (CLOSED) and the input stalls until the output register frees.
module fan_line_packer
  import fan_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fan_line_packer_if.slave bus
`ifdef FAN_PACK_STATS_EN
  ,
  output logic [31:0] stat_lines,
  output logic [31:0] stat_pad
`endif
);

  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_CLOSED = 1'b1;

  logic [0:0]                   state;
  logic [DW_CNT-1:0]            cnt;
  logic                         rdy_en;
  logic [NUM_LANE*DW_PAYLOAD-1:0] buf_data;
  logic [NUM_LANE*DW_ROW-1:0]     buf_row;

  logic [NUM_LANE*DW_PAYLOAD-1:0] asm_data;
  logic [NUM_LANE*DW_ROW-1:0]     asm_row;
  logic [NUM_LANE*DW_PAYLOAD-1:0] src_data;
  logic [NUM_LANE*DW_ROW-1:0]     src_row;
  logic [DW_CNT-1:0]              src_cnt;
  logic [NUM_LANE-1:0]            src_valid;
  logic [NUM_LANE*DW_CTRL-1:0]    src_ctrl;
  line_t                          src_line;

  logic out_free;
  logic accept;
  logic close_now;
  logic load;

  assign out_free     = !bus.m_valid || bus.m_ready;
  assign bus.s_ready  = rdy_en && !((state == ST_CLOSED) && !out_free);
  assign accept       = bus.s_valid && bus.s_ready;
  assign close_now    = accept && (state == ST_FILL) &&
                        (bus.s_last || (cnt == DW_CNT'(NUM_LANE - 1)));
  assign load         = (state == ST_FILL) ? (close_now && out_free) : out_free;

  // Fill buffer with the element offered this cycle dropped into lane cnt
  always_comb begin
    asm_data = buf_data;
    asm_row  = buf_row;
    asm_data[cnt[DW_CNT-2:0]*DW_PAYLOAD +: DW_PAYLOAD] = bus.s_data;
    asm_row[cnt[DW_CNT-2:0]*DW_ROW +: DW_ROW]         = bus.s_row;
  end

  // Line source for the output register: parked line when CLOSED,
  // otherwise the line being closed this cycle
  always_comb begin
    if (state == ST_CLOSED) begin
      src_data = buf_data;
      src_row  = buf_row;
      src_cnt  = cnt;
    end else begin
      src_data = asm_data;
      src_row  = asm_row;
      src_cnt  = cnt + 1'b1;
    end
  end

  fan_ctrl_gen u_ctrl_gen (
    .valid (src_valid),
    .rows  (src_row),
    .ctrl  (src_ctrl)
  );

  // Unfilled lanes are forced to all-zero so stale buffer contents never leak
  for (genvar i = 0; i < NUM_LANE; i++) begin : g_pack
    assign src_valid[i] = (DW_CNT'(i) < src_cnt);
    assign src_line[i*DW_LINE +: DW_LINE] = src_valid[i] ?
      pack_lane(src_ctrl[i*DW_CTRL +: DW_CTRL],
                src_row[i*DW_ROW +: DW_ROW],
                src_data[i*DW_PAYLOAD +: DW_PAYLOAD]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FILL;
      cnt         <= '0;
      rdy_en      <= 1'b0;
      buf_data    <= '0;
      buf_row     <= '0;
      bus.m_valid <= 1'b0;
      bus.m_line  <= '0;
    end else begin
      rdy_en <= 1'b1;

      if (load) begin
        bus.m_valid <= 1'b1;
        bus.m_line  <= src_line;
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end

      case (state)
        ST_FILL: begin
          if (accept) begin
            buf_data <= asm_data;
            buf_row  <= asm_row;
            if (close_now && out_free) begin
              cnt <= '0;
            end else if (close_now) begin
              cnt   <= cnt + 1'b1;
              state <= ST_CLOSED;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          // Parked line leaves this cycle; a new element may start the next
          // line in lane 0 at the same edge
          if (out_free) begin
            if (accept) begin
              buf_data[0 +: DW_PAYLOAD] <= bus.s_data;
              buf_row[0 +: DW_ROW]      <= bus.s_row;
              cnt   <= DW_CNT'(1);
              state <= bus.s_last ? ST_CLOSED : ST_FILL;
            end else begin
              cnt   <= '0;
              state <= ST_FILL;
            end
          end
        end
      endcase
    end
  end

`ifdef FAN_PACK_STATS_EN
  logic [DW_CNT-1:0] out_pad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pad    <= '0;
      stat_lines <= '0;
      stat_pad   <= '0;
    end else begin
      if (load) begin
        out_pad <= DW_CNT'(NUM_LANE) - src_cnt;
      end
      if (bus.m_valid && bus.m_ready) begin
        stat_lines <= stat_lines + 32'd1;
        stat_pad   <= stat_pad + 32'(out_pad);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fan_line_packer.sv
// tb_fan_line_packer -- self-checking bench for fan_line_packer.
// Directed tile scenarios followed by randomized traffic with random
// backpressure; expected lines come from a queue-based line model.
module tb_fan_line_packer;
  import fan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fan_line_packer_if bus_if ();

`ifdef FAN_PACK_STATS_EN
  logic [31:0] stat_lines;
  logic [31:0] stat_pad;
`endif

  fan_line_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef FAN_PACK_STATS_EN
    ,
    .stat_lines (stat_lines),
    .stat_pad   (stat_pad)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_handoff = 0;
  int mr_mode = 0;  // 0: m_ready=1, 1: m_ready=0, 2: random

  logic [NUM_LANE*DW_LINE-1:0] exp_q[$];
  int    pad_q[$];
  data_t cur_data[$];
  row_t  cur_row[$];
  logic [31:0] exp_lines = 0;
  logic [31:0] exp_pad = 0;
  line_t mon_line;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a line is the list of accepted elements, each lane flagged with
  // whether its neighbours in the list share its row.
  function automatic line_t build_line();
    line_t l = '0;
    int n = cur_data.size();
    for (int i = 0; i < n; i++) begin
      ctrl_t c = '0;
      c[CTRL_VALID] = 1'b1;
      if (i + 1 < n && cur_row[i+1] == cur_row[i]) c[CTRL_CONT_R] = 1'b1;
      if (i > 0 && cur_row[i-1] == cur_row[i])     c[CTRL_CONT_L] = 1'b1;
      l[i*DW_LINE +: DW_LINE] = {c, cur_row[i], cur_data[i]};
    end
    return l;
  endfunction

  // m_ready driver
  always @(posedge clk) begin
    #2;
    case (mr_mode)
      0:       bus_if.m_ready = 1'b1;
      1:       bus_if.m_ready = 1'b0;
      default: bus_if.m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: sampled at negedge, both handshakes complete at the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_data.delete();
      cur_row.delete();
      exp_lines = 0;
      exp_pad = 0;
    end else begin
      if (bus_if.m_valid && bus_if.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_line", 1, 0);
        end else begin
          mon_line = exp_q.pop_front();
          for (int i = 0; i < NUM_LANE; i++)
            chk($sformatf("line%0d_lane%0d", n_handoff, i),
                256'(bus_if.m_line[i*DW_LINE +: DW_LINE]),
                256'(mon_line[i*DW_LINE +: DW_LINE]));
          n_handoff++;
          exp_lines = exp_lines + 1;
          exp_pad = exp_pad + 32'(pad_q.pop_front());
        end
      end
      if (bus_if.s_valid && bus_if.s_ready) begin
        cur_data.push_back(bus_if.s_data);
        cur_row.push_back(bus_if.s_row);
        if (cur_data.size() == NUM_LANE || bus_if.s_last) begin
          exp_q.push_back(build_line());
          pad_q.push_back(NUM_LANE - cur_data.size());
          cur_data.delete();
          cur_row.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic data_t rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents one element and returns at the negedge before its accept edge
  task automatic send(input data_t d, input row_t r, input logic last, output int waits);
    waits = 0;
    @(posedge clk); #1;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = d;
    bus_if.s_row   = r;
    bus_if.s_last  = last;
    @(negedge clk);
    while (!bus_if.s_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!bus_if.s_ready) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus_if.s_valid = 1'b0;
    bus_if.s_last  = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    idle();
    mr_mode = 0;
    while ((exp_q.size() != 0 || bus_if.m_valid) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", 256'(exp_q.size()), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] t1_rows [8] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3};
  logic [3:0] t1_ctrl [8] = '{4'h9, 4'hA, 4'h9, 4'hB, 4'hA, 4'h8, 4'h9, 4'hA};
  logic [3:0] t2_ctrl [3] = '{4'h9, 4'hA, 4'h8};

  initial begin
    int w;
    int stalls;
    int h0;
    int k;
    line_t held;
    logic got;

    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.s_row   = '0;
    bus_if.s_last  = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 256'(bus_if.s_ready), 0);
    chk("rst_m_valid", 256'(bus_if.m_valid), 0);
    chk("rst_m_line_zero", 256'(bus_if.m_line == '0), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_s_ready_low", 256'(bus_if.s_ready), 0);
    @(negedge clk);
    chk("release_s_ready_high", 256'(bus_if.s_ready), 1);

    // Test 1: full line with row runs, latency 1
    for (int i = 0; i < 8; i++) send(rand_data(), t1_rows[i], 1'b0, w);
    chk("t1_m_valid_before", 256'(bus_if.m_valid), 0);
    idle();
    @(negedge clk);
    chk("t1_m_valid_after", 256'(bus_if.m_valid), 1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t1_ctrl%0d", i),
          256'(bus_if.m_line[i*DW_LINE + LANE_CTRL_LSB +: DW_CTRL]), 256'(t1_ctrl[i]));
    drain();

    // Test 2: short tile flushed by s_last, padded lanes zero
    send(rand_data(), 4'd5, 1'b0, w);
    send(rand_data(), 4'd5, 1'b0, w);
    send(rand_data(), 4'd6, 1'b1, w);
    idle();
    @(negedge clk);
    chk("t2_m_valid", 256'(bus_if.m_valid), 1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_ctrl%0d", i),
          256'(bus_if.m_line[i*DW_LINE + LANE_CTRL_LSB +: DW_CTRL]), 256'(t2_ctrl[i]));
    for (int i = 3; i < NUM_LANE; i++)
      chk($sformatf("t2_pad%0d", i), 256'(bus_if.m_line[i*DW_LINE +: DW_LINE]), 0);
    drain();

    // Test 3: 24 elements back-to-back, no stall
    stalls = 0;
    h0 = n_handoff;
    for (int i = 0; i < 24; i++) begin
      send(rand_data(), 4'($urandom_range(0, 3)), 1'b0, w);
      stalls += w;
    end
    drain();
    chk("t3_stalls", 256'(stalls), 0);
    chk("t3_lines", 256'(n_handoff - h0), 3);

    // Test 4: backpressure for 20 cycles
    mr_mode = 1;
    repeat (2) @(posedge clk);
    h0 = n_handoff;
    k = 0;
    got = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (got) begin
        bus_if.s_data = rand_data();
        bus_if.s_row  = 4'($urandom_range(0, 3));
      end
      bus_if.s_valid = 1'b1;
      bus_if.s_last  = 1'b0;
      @(negedge clk);
      got = bus_if.s_ready;
      if (got) k++;
      if (c == 12) held = bus_if.m_line;
    end
    chk("t4_accepts", 256'(k), 16);
    chk("t4_s_ready_low", 256'(bus_if.s_ready), 0);
    chk("t4_m_valid_held", 256'(bus_if.m_valid), 1);
    chk("t4_line_stable", 256'(bus_if.m_line == held), 1);
    drain();
    chk("t4_lines", 256'(n_handoff - h0), 2);

    // Test 5: reset in the middle of a line
    for (int i = 0; i < 4; i++) send(rand_data(), 4'(i), 1'b0, w);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_m_valid_rst", 256'(bus_if.m_valid), 0);
    chk("t5_s_ready_rst", 256'(bus_if.s_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    h0 = n_handoff;
    for (int i = 0; i < 8; i++) send(rand_data(), 4'(i / 2), 1'b0, w);
    drain();
    chk("t5_lines", 256'(n_handoff - h0), 1);

    // Test 6: all rows distinct
    for (int i = 0; i < 8; i++) send(rand_data(), 4'(i + 8), 1'b0, w);
    idle();
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t6_ctrl%0d", i),
          256'(bus_if.m_line[i*DW_LINE + LANE_CTRL_LSB +: DW_CTRL]), 256'h8);
    drain();

    // Random traffic with random backpressure and gaps
    mr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(rand_data(), 4'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), w);
      if ($urandom_range(0, 4) == 0) idle();
    end
    drain();

`ifdef FAN_PACK_STATS_EN
    repeat (2) @(negedge clk);
    chk("stat_lines", 256'(stat_lines), 256'(exp_lines));
    chk("stat_pad", 256'(stat_pad), 256'(exp_pad));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
